// File: rtl/instruction_fetch_queue_pkg.sv
// instruction_fetch_queue_pkg: shared widths and the queue entry pairing a fetched word with its PC.
package instruction_fetch_queue_pkg;
    localparam int WORD_SIZE = 32;
    localparam int PC_INCREMENT = 4;
    localparam int PC_MAX_BITS = 32;
    typedef struct packed {
        logic [PC_MAX_BITS-1:0] pc;
        logic [WORD_SIZE-1:0]   instr;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_queue_if.sv
// instruction_fetch_queue_if: memory-side fetch bus plus core-side instruction handshake.
interface instruction_fetch_queue_if
    import instruction_fetch_queue_pkg::*;
#(
    parameter int BIT_COUNT = 32
);
    logic [BIT_COUNT-1:0] InstrAdr, RedirectPC, InstrPC;
    logic [WORD_SIZE-1:0] MemInstr, Instr;
    logic                 Redirect, InstrValid, InstrReady;
    modport master (
        output InstrAdr, InstrValid, Instr, InstrPC,
        input  MemInstr, Redirect, RedirectPC, InstrReady
    );
    modport slave (
        input  InstrAdr, InstrValid, Instr, InstrPC,
        output MemInstr, Redirect, RedirectPC, InstrReady
    );
endinterface

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// fetch_fifo: circular entry store with flush; pointers wrap modulo DEPTH (power of two).
module fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   count_q;
    always_ff @(posedge clk)
        if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= push_i ? wr_q + PW'(1) : wr_q;
            rd_q    <= pop_i ? rd_q + PW'(1) : rd_q;
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push_i && !pop_i && !flush_i && count_q == (PW+1)'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(pop_i && !flush_i && count_q == '0));
endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: credit-limited sequential fetcher feeding a small instruction queue.
// A fetch is issued only if its return is guaranteed a free slot, so the queue never overflows.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int                   BIT_COUNT = 32,
    parameter int                   DEPTH     = 4,
    parameter logic [BIT_COUNT-1:0] RESET_PC  = '0
) (
    input logic                    clk,
    input logic                    reset,
    instruction_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_entry_t         head, push_entry;
    logic [CW-1:0]        count;
    logic [CW:0]          credit;
    logic [BIT_COUNT-1:0] fetch_pc_q, fetch_pc_d, pend_pc_q;
    logic                 pend_q, pop, push, issue;
    assign pop    = bus.InstrValid && bus.InstrReady && !bus.Redirect;
    assign push   = pend_q && !bus.Redirect;
    assign credit = {1'b0, count} + (CW+1)'(pend_q) - (CW+1)'(pop);
    assign issue  = !bus.Redirect && credit < (CW+1)'(DEPTH);
    always_comb begin
        push_entry.pc    = PC_MAX_BITS'(pend_pc_q);
        push_entry.instr = bus.MemInstr;
        fetch_pc_d = bus.Redirect ? {bus.RedirectPC[BIT_COUNT-1:2], 2'b00}
                   : issue        ? fetch_pc_q + BIT_COUNT'(PC_INCREMENT)
                   :                fetch_pc_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= issue;
            pend_pc_q  <= fetch_pc_q;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .flush_i    (bus.Redirect),
        .head_o     (head),
        .count_o    (count)
    );
    assign bus.InstrAdr   = fetch_pc_q;
    assign bus.InstrValid = count != '0;
    assign bus.Instr      = bus.InstrValid ? head.instr : '0;
    assign bus.InstrPC    = bus.InstrValid ? head.pc[BIT_COUNT-1:0] : '0;
endmodule
